// File: rtl/clkdiv_pkg.sv
// clkdiv_sched shared types and levels.
// Thresholds and output levels are given in millivolts and scaled by from_mv.
package clkdiv_pkg;

  typedef enum logic {IDLE, RUN} sched_state_t;
  typedef enum logic {MODE_GATE, MODE_TRIG} out_mode_t;

  localparam int SCHMITT_HI_MV = 2000;
  localparam int SCHMITT_LO_MV = 500;
  localparam int OUT_HI_MV     = 5000;
  localparam int OUT_LO_MV     = 0;

  function automatic int from_mv(input int mv, input int fp);
    return mv * (1 << fp);
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divider channel (phase counter, ratio/mode latch, shaper).
// Ports: strobe/clk_edge/clk_level/sync/restart/run from top, div/trig/len cfg, sample out.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int W         = 16,
  parameter int FP_OFFSET = 2,
  parameter int CW        = 8,
  parameter int TLW       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                strobe,
  input  logic                clk_edge,
  input  logic                clk_level,
  input  logic                sync,
  input  logic                restart,
  input  logic                run,
  input  logic [CW-1:0]       div,
  input  logic                trig,
  input  logic [TLW-1:0]      len,
  output logic signed [W-1:0] sample
);

  localparam logic signed [W-1:0] LVL_HI =
    W'(from_mv(OUT_HI_MV, FP_OFFSET));
  localparam logic signed [W-1:0] LVL_LO =
    W'(from_mv(OUT_LO_MV, FP_OFFSET));

  logic [CW-1:0]  phase, phase_nx;
  logic [CW-1:0]  ratio, ratio_nx;
  logic [CW-1:0]  pos, pos_nx;
  logic [CW-1:0]  base;
  logic [CW:0]    half;
  logic [TLW-1:0] tcnt, tcnt_nx;
  out_mode_t      mode, mode_nx;
  logic           fire;
  logic           hi;

  always_comb begin
    phase_nx = phase;
    ratio_nx = ratio;
    pos_nx   = pos;
    tcnt_nx  = tcnt;
    mode_nx  = mode;
    base     = phase;
    fire     = 1'b0;
    if (sync) begin
      phase_nx = '0;
      tcnt_nx  = '0;
    end else if (tcnt != '0) begin
      tcnt_nx = tcnt - 1'b1;
    end
    if (clk_edge) begin
      // sync or leaving IDLE makes this edge the first of a period
      if (restart || sync) base = '0;
      fire = (base == '0);
      if (fire) begin
        ratio_nx = (div == '0) ? CW'(1) : div;
        mode_nx  = trig ? MODE_TRIG : MODE_GATE;
      end
      pos_nx   = base;
      phase_nx = (base + 1'b1 == ratio_nx) ? '0 : base + 1'b1;
      if (fire && mode_nx == MODE_TRIG)
        tcnt_nx = (len == '0) ? TLW'(1) : len;
    end
  end

  // high for the first ceil(N/2) edges of each period
  assign half = ({1'b0, ratio_nx} + 1'b1) >> 1;

  always_comb begin
    hi = 1'b0;
    unique case (1'b1)
      mode_nx == MODE_TRIG:
        hi = (tcnt_nx != '0);
      mode_nx == MODE_GATE && !run:
        hi = 1'b0;
      mode_nx == MODE_GATE && run && ratio_nx == CW'(1):
        hi = clk_level;
      mode_nx == MODE_GATE && run && ratio_nx != CW'(1):
        hi = ({1'b0, pos_nx} < half);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= '0;
      ratio  <= CW'(1);
      pos    <= '0;
      tcnt   <= '0;
      mode   <= MODE_GATE;
      sample <= LVL_LO;
    end else if (strobe) begin
      phase  <= phase_nx;
      ratio  <= ratio_nx;
      pos    <= pos_nx;
      tcnt   <= tcnt_nx;
      mode   <= mode_nx;
      sample <= hi ? LVL_HI : LVL_LO;
    end
  end

endmodule

// File: rtl/clkdiv_sched.sv
// clkdiv_sched: Schmitt clock/sync detect, run/idle FSM, four divider channels.
// Ports: sample_strobe, sample_in0..3, cfg_div0..3, cfg_trig_mode/len -> sample_out0..3, running.
module clkdiv_sched
  import clkdiv_pkg::*;
#(
  parameter int W         = 16,
  parameter int FP_OFFSET = 2,
  parameter int CW        = 8,
  parameter int TLW       = 16,
  parameter int TIMEOUT   = 96000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_strobe,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  input  logic [CW-1:0]       cfg_div0,
  input  logic [CW-1:0]       cfg_div1,
  input  logic [CW-1:0]       cfg_div2,
  input  logic [CW-1:0]       cfg_div3,
  input  logic [3:0]          cfg_trig_mode,
  input  logic [TLW-1:0]      cfg_trig_len,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3,
  output logic                running
);

  localparam int TOW = $clog2(TIMEOUT + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);
  localparam logic signed [W-1:0] TH_HI =
    W'(from_mv(SCHMITT_HI_MV, FP_OFFSET));
  localparam logic signed [W-1:0] TH_LO =
    W'(from_mv(SCHMITT_LO_MV, FP_OFFSET));

  sched_state_t   state, state_nx;
  logic [TOW-1:0] tcnt;
  logic           clk_st, clk_nx, clk_edge;
  logic           sync_st, sync_nx, sync_edge;
  logic           unused_in;

  assign unused_in = ^{sample_in2, sample_in3};

  always_comb begin
    clk_nx = clk_st;
    if (sample_in0 > TH_HI)      clk_nx = 1'b1;
    else if (sample_in0 < TH_LO) clk_nx = 1'b0;
    sync_nx = sync_st;
    if (sample_in1 > TH_HI)      sync_nx = 1'b1;
    else if (sample_in1 < TH_LO) sync_nx = 1'b0;
  end

  assign clk_edge  = sample_strobe & clk_nx & ~clk_st;
  assign sync_edge = sample_strobe & sync_nx & ~sync_st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_st  <= 1'b0;
      sync_st <= 1'b0;
    end else if (sample_strobe) begin
      clk_st  <= clk_nx;
      sync_st <= sync_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // sync lands first; a coincident clock edge then restarts as edge 0
  always_comb begin
    state_nx = state;
    if (sync_edge) state_nx = IDLE;
    if (clk_edge)
      state_nx = RUN;
    else if (sample_strobe && !sync_edge &&
             state == RUN && tcnt == TO_LAST)
      state_nx = IDLE;
  end

  always_comb begin
    running = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= '0;
    else if (sample_strobe) begin
      if (clk_edge || state_nx == IDLE) tcnt <= '0;
      else                              tcnt <= tcnt + 1'b1;
    end
  end

  logic [CW-1:0]       div [4];
  logic signed [W-1:0] outs [4];

  assign div[0] = cfg_div0;
  assign div[1] = cfg_div1;
  assign div[2] = cfg_div2;
  assign div[3] = cfg_div3;

  for (genvar k = 0; k < 4; k++) begin : g_ch
    clkdiv_chan #(
      .W(W), .FP_OFFSET(FP_OFFSET), .CW(CW), .TLW(TLW)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .strobe    (sample_strobe),
      .clk_edge  (clk_edge),
      .clk_level (clk_nx),
      .sync      (sync_edge),
      .restart   (state == IDLE),
      .run       (state_nx == RUN),
      .div       (div[k]),
      .trig      (cfg_trig_mode[k]),
      .len       (cfg_trig_len),
      .sample    (outs[k])
    );
  end

  assign sample_out0 = outs[0];
  assign sample_out1 = outs[1];
  assign sample_out2 = outs[2];
  assign sample_out3 = outs[3];

endmodule

// File: tb/tb_clkdiv_sched.sv
// tb_clkdiv_sched: scoreboard bench for clkdiv_sched.
// A behavioural model queues expected outputs per sample; directed checks cover key cases.
module tb_clkdiv_sched;

  localparam int W   = 16;
  localparam int CW  = 8;
  localparam int TLW = 16;
  localparam int TO  = 64;
  localparam int HI  = 20000;
  localparam int THH = 8000;
  localparam int THL = 2000;

  typedef struct packed {
    int o0; int o1; int o2; int o3; bit run;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic strobe = 1'b0;
  logic signed [W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic [CW-1:0] div [4];
  logic [3:0] tmode = 4'h0;
  logic [TLW-1:0] tlen = TLW'(1);
  logic signed [W-1:0] out0, out1, out2, out3;
  logic running;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  bit m_c, m_s, m_run;
  int m_to;
  int m_ph[4], m_n[4], m_pos[4], m_tc[4];
  bit m_md[4];

  clkdiv_sched #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .sample_strobe(strobe),
    .sample_in0(in0), .sample_in1(in1),
    .sample_in2(in2), .sample_in3(in3),
    .cfg_div0(div[0]), .cfg_div1(div[1]),
    .cfg_div2(div[2]), .cfg_div3(div[3]),
    .cfg_trig_mode(tmode), .cfg_trig_len(tlen),
    .sample_out0(out0), .sample_out1(out1),
    .sample_out2(out2), .sample_out3(out3),
    .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got,
                       input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_c = 0; m_s = 0; m_run = 0; m_to = 0;
    for (int k = 0; k < 4; k++) begin
      m_ph[k] = 0; m_n[k] = 1; m_pos[k] = 0;
      m_tc[k] = 0; m_md[k] = 0;
    end
  endtask

  task automatic model_step(input int a0, input int a1,
                            output exp_t e);
    bit cn, sn, ce, se, was_idle;
    int v[4];
    cn = (a0 > THH) ? 1'b1 : (a0 < THL) ? 1'b0 : m_c;
    sn = (a1 > THH) ? 1'b1 : (a1 < THL) ? 1'b0 : m_s;
    ce = cn && !m_c;
    se = sn && !m_s;
    m_c = cn;
    m_s = sn;
    if (se) begin
      m_run = 0; m_to = 0;
      for (int k = 0; k < 4; k++) begin
        m_ph[k] = 0; m_tc[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++)
        if (m_tc[k] > 0) m_tc[k]--;
    end
    if (ce) begin
      was_idle = !m_run;
      m_run = 1; m_to = 0;
      for (int k = 0; k < 4; k++) begin
        if (was_idle) m_ph[k] = 0;
        if (m_ph[k] == 0) begin
          m_n[k] = (div[k] == 0) ? 1 : int'(div[k]);
          m_md[k] = tmode[k];
          if (m_md[k]) m_tc[k] = (tlen == 0) ? 1 : int'(tlen);
        end
        m_pos[k] = m_ph[k];
        m_ph[k] = (m_ph[k] + 1) % m_n[k];
      end
    end else if (m_run) begin
      if (m_to == TO - 1) begin
        m_run = 0; m_to = 0;
      end else m_to++;
    end
    for (int k = 0; k < 4; k++) begin
      if (m_md[k])         v[k] = (m_tc[k] > 0) ? HI : 0;
      else if (!m_run)     v[k] = 0;
      else if (m_n[k] == 1) v[k] = m_c ? HI : 0;
      else v[k] = (2 * m_pos[k] < m_n[k]) ? HI : 0;
    end
    e.o0 = v[0]; e.o1 = v[1]; e.o2 = v[2]; e.o3 = v[3];
    e.run = m_run;
  endtask

  task automatic compare();
    exp_t e;
    if (sbq.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sbq.pop_front();
    check("out0", int'(out0), e.o0);
    check("out1", int'(out1), e.o1);
    check("out2", int'(out2), e.o2);
    check("out3", int'(out3), e.o3);
    check("running", int'(running), int'(e.run));
  endtask

  // one strobe cycle plus an idle cycle; both must show the model values
  task automatic sample(input int a0, input int a1);
    exp_t e;
    in0 = W'(a0);
    in1 = W'(a1);
    in2 = W'($urandom_range(0, 30000));
    in3 = W'($urandom_range(0, 30000));
    model_step(a0, a1, e);
    sbq.push_back(e);
    sbq.push_back(e);
    strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
    compare();
    @(posedge clk); #1;
    compare();
  endtask

  task automatic pulse_rest(input int n_hi, input int n_lo);
    for (int i = 0; i < n_hi; i++) sample(HI, 0);
    for (int i = 0; i < n_lo; i++) sample(0, 0);
  endtask

  task automatic do_sync();
    sample(0, HI);
    sample(0, 0);
  endtask

  initial begin
    int cnt;
    int pat1[8];
    pat1 = '{HI, HI, 0, 0, HI, 0, HI, 0};
    div[0] = 8'd1; div[1] = 8'd2; div[2] = 8'd4; div[3] = 8'd8;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out0", int'(out0), 0);
    check("rst_out3", int'(out3), 0);
    check("rst_run", int'(running), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // gate dividers 1/2/4/8
    for (int e = 0; e < 8; e++) begin
      sample(HI, 0);
      check("div_out1", int'(out1), (e % 2 == 0) ? HI : 0);
      check("div_out3", int'(out3), (e < 4) ? HI : 0);
      check("div_run", int'(running), 1);
      pulse_rest(3, 4);
    end

    // hysteresis: 1500 mV is between thresholds
    for (int i = 0; i < 4; i++) sample(6000, 0);
    check("hyst_hold", int'(out1), 0);
    sample(8400, 0);
    check("hyst_edge", int'(out1), HI);
    pulse_rest(0, 4);

    // trigger mode on ch0, /3, len 5 then len 0
    do_sync();
    check("sync_run", int'(running), 0);
    check("sync_out3", int'(out3), 0);
    div[0] = 8'd3; tmode = 4'b0001; tlen = TLW'(5);
    for (int e = 0; e < 12; e++) begin
      if (e == 9) tlen = '0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
        sample((i < 4) ? HI : 0, 0);
        if (out0 == W'(HI)) cnt++;
      end
      check("trig_cnt", cnt,
            (e % 3 != 0) ? 0 : (e < 9) ? 5 : 1);
    end

    // ratio change mid-period on ch1
    do_sync();
    div[1] = 8'd4;
    for (int e = 0; e < 8; e++) begin
      sample(HI, 0);
      check("chg_out1", int'(out1), pat1[e]);
      if (e == 0) div[1] = 8'd2;
      pulse_rest(3, 4);
    end

    // sync coincident with clock edge 5
    do_sync();
    for (int e = 0; e < 5; e++) pulse_rest(4, 4);
    sample(HI, HI);
    check("co_run", int'(running), 1);
    check("co_out0", int'(out0), HI);
    check("co_out1", int'(out1), HI);
    check("co_out2", int'(out2), HI);
    check("co_out3", int'(out3), HI);
    pulse_rest(3, 4);

    // timeout back to IDLE
    sample(HI, 0);
    for (int i = 0; i < TO - 1; i++) sample(0, 0);
    check("to_before", int'(running), 1);
    sample(0, 0);
    check("to_run", int'(running), 0);
    check("to_out1", int'(out1), 0);
    check("to_out2", int'(out2), 0);
    check("to_out3", int'(out3), 0);
    sample(HI, 0);
    check("to_refire1", int'(out1), HI);
    check("to_refire2", int'(out2), HI);
    check("to_refire3", int'(out3), HI);
    pulse_rest(3, 4);

    // asynchronous reset in the middle of trigger pulses
    tmode = 4'hF; tlen = TLW'(20);
    do_sync();
    pulse_rest(3, 0);
    check("pre_arst", int'(out2), HI);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_out0", int'(out0), 0);
    check("arst_out2", int'(out2), 0);
    check("arst_run", int'(running), 0);
    model_reset();
    tmode = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sample(0, 0);
    pulse_rest(4, 4);
    pulse_rest(4, 4);

    check("sb_drain", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
